rf_mcu_to_node_packetizer: RTL

Mode-0 transmit-direction packetizer for the RF transceiver: accepts bytes strobed in from the MCU-side UART receiver, buffers them in a FIFO, and, on a length or inter-byte idle trigger, emits a framed packet to the node-side UART transmitter. A frame is `HEADER_BYTE`, then a length byte, then the payload. `AUX` reports busy/idle to the external MCU.

---
 rtl/rf_mcu_to_node_packetizer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_mcu_to_node_packetizer.sv
// rf_mcu_to_node_packetizer: buffers MCU UART bytes and emits HEADER/len/payload frames to the node UART.
// Latency: header strobe 1 cycle after the write reaching MAX_PACKET, or IDLE_TIMEOUT+1 cycles after the last write.
// Backpressure: one byte per node-UART busy cycle; writes into a full FIFO are dropped with an overflow pulse.

// Show-ahead FIFO: dout is the current head, pop consumes it; push into a full FIFO is ignored.
module rf_mcu_to_node_packetizer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module rf_mcu_to_node_packetizer #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    FIFO_DEPTH   = 512,
  parameter int                    IDLE_TIMEOUT = 2000,
  parameter int                    MAX_PACKET   = 58,
  parameter logic [DATA_WIDTH-1:0] HEADER_BYTE  = 8'hFF
) (
  input  logic                  internal_clk,
  input  logic                  rst,
  input  logic                  M0_sync,
  input  logic                  M1_sync,
  input  logic                  RX_flag_mcu,
  input  logic [DATA_WIDTH-1:0] data_from_uart_mcu,
  input  logic                  TX_use_node,
  output logic                  TX_flag_node,
  output logic [DATA_WIDTH-1:0] data_to_uart_node,
  output logic                  AUX,
  output logic                  overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PACKET);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state;
  logic                  rx_prev;
  logic                  wr;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         count;
  logic [IW-1:0]         idle_cnt;
  logic [7:0]            len;
  logic [7:0]            len_next;
  logic [8:0]            idx;
  logic                  mode_tx;
  logic                  start_frame;

  // A write is the rising edge of the MCU receive flag, so a held-high flag stores one byte.
  assign wr = RX_flag_mcu & ~rx_prev;

  // Payload bytes leave the FIFO only while their own strobe is on the wire (index 2 onward).
  assign pop = (state == S_SEND) && (idx >= 9'd2);

  assign mode_tx     = ~M1_sync & ~M0_sync;
  assign len_next    = (count >= MAX_CNT) ? 8'(MAX_PACKET) : 8'(count);
  assign start_frame = mode_tx && ((count >= MAX_CNT) || ((idle_cnt == IDLE_MAX) && !fifo_empty));

  rf_mcu_to_node_packetizer_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (internal_clk),
    .rst   (rst),
    .push  (wr),
    .pop   (pop),
    .din   (data_from_uart_mcu),
    .dout  (fifo_head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Previous value of the receive flag for edge detection.
  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) rx_prev <= 1'b0;
    else     rx_prev <= RX_flag_mcu;
  end

  // Flag a dropped byte for one cycle when a write hits a full FIFO.
  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= wr & fifo_full;
  end

  // Inter-byte idle timer: restarts on each stored byte, parked at zero in IDLE, saturates at the timeout.
  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((wr && !fifo_full) || (state == S_IDLE)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Framing FSM; the strobe and byte are loaded on entry to SEND so both are valid during SEND.
  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= '0;
      len               <= '0;
      TX_flag_node      <= 1'b0;
      data_to_uart_node <= '0;
      AUX               <= 1'b1;
    end else begin
      TX_flag_node <= 1'b0;
      AUX          <= (state == S_IDLE) && fifo_empty;
      case (state)
        S_IDLE: begin
          // A byte pushed in the same cycle the last frame finished must not be stranded.
          if (wr || !fifo_empty) state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (start_frame) begin
            state             <= S_SEND;
            len               <= len_next;
            idx               <= '0;
            TX_flag_node      <= 1'b1;
            data_to_uart_node <= HEADER_BYTE;
          end
        end
        S_SEND: begin
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (TX_use_node) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!TX_use_node) begin
            if (idx == ({1'b0, len} + 9'd1)) begin
              state <= fifo_empty ? S_IDLE : S_COLLECT;
            end else begin
              state             <= S_SEND;
              idx               <= idx + 9'd1;
              TX_flag_node      <= 1'b1;
              data_to_uart_node <= (idx == 9'd0) ? DATA_WIDTH'(len) : fifo_head;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
